// File: rtl/beat_sequencer.sv
// beat_sequencer: prescaled beat index generator with play/pause/stop control.
// Optional feature macro: BEAT_SEQUENCER_FAST_EN adds a 'fast' input for double tempo.
module beat_sequencer #(
    parameter int unsigned DIV      = 12_500_000,
    parameter int unsigned BEAT_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        stop,
    input  logic        loop_en,
`ifdef BEAT_SEQUENCER_FAST_EN
    input  logic        fast,
`endif
    output logic [11:0] ibeatNum,
    output logic        beat_tick,
    output logic        playing,
    output logic        song_done
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = 12;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BEAT_LEN - 1);
    localparam logic [CNT_W-1:0] TERM_SLOW = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   div_cnt, div_cnt_n;
    logic [IDX_W-1:0]   idx_n;
    logic               tick_n, done_n;
    logic [CNT_W-1:0]   term;
    logic               run;

`ifdef BEAT_SEQUENCER_FAST_EN
    localparam logic [CNT_W-1:0] TERM_FAST = CNT_W'((DIV / 2) - 1);
    assign term = fast ? TERM_FAST : TERM_SLOW;
`else
    assign term = TERM_SLOW;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_STOP;
            div_cnt   <= '0;
            ibeatNum  <= '0;
            beat_tick <= 1'b0;
            song_done <= 1'b0;
            playing   <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_cnt_n;
            ibeatNum  <= idx_n;
            beat_tick <= tick_n;
            song_done <= done_n;
            playing   <= (state_n == ST_PLAY);
        end
    end

    // Next state, prescaler and beat advance. The resume edge counts as a
    // PLAY cycle so a pause of (r-p) edges delays the beat by exactly r-p.
    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        idx_n     = ibeatNum;
        tick_n    = 1'b0;
        done_n    = 1'b0;
        run       = 1'b0;

        if (stop) begin
            state_n   = ST_STOP;
            div_cnt_n = '0;
            idx_n     = '0;
        end else begin
            case (state)
                ST_STOP: begin
                    div_cnt_n = '0;
                    idx_n     = '0;
                    if (play) state_n = ST_PLAY;
                end
                ST_PLAY: begin
                    if (play) state_n = ST_PAUSE;
                    else      run     = 1'b1;
                end
                ST_PAUSE: begin
                    if (play) begin
                        state_n = ST_PLAY;
                        run     = 1'b1;
                    end
                end
                default: begin
                    state_n   = ST_STOP;
                    div_cnt_n = '0;
                    idx_n     = '0;
                end
            endcase

            if (run) begin
                if (div_cnt >= term) begin
                    div_cnt_n = '0;
                    if (ibeatNum >= LAST_IDX) begin
                        idx_n  = '0;
                        done_n = 1'b1;
                        if (loop_en) tick_n  = 1'b1;
                        else         state_n = ST_STOP;
                    end else begin
                        idx_n  = ibeatNum + IDX_W'(1);
                        tick_n = 1'b1;
                    end
                end else begin
                    div_cnt_n = div_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer with an elapsed-time reference model.
module tb_beat_sequencer;

    localparam int DIV      = 4;
    localparam int BEAT_LEN = 8;

    logic        clk;
    logic        rst_n;
    logic        play;
    logic        stop;
    logic        loop_en;
    logic [11:0] ibeatNum;
    logic        beat_tick;
    logic        playing;
    logic        song_done;
`ifdef BEAT_SEQUENCER_FAST_EN
    logic        fast;
`endif

    int total;
    int bad;

    // Reference model: mode 0=stop 1=play 2=pause, m_e = play cycles into song.
    int          m_mode;
    int          m_e;
    logic        m_tick;
    logic        m_done;
    logic [11:0] m_idx;
    logic        m_play;

    logic [14:0] got;
    logic [14:0] want;
    assign got  = {ibeatNum, beat_tick, playing, song_done};
    assign want = {m_idx, m_tick, m_play, m_done};

    beat_sequencer #(.DIV(DIV), .BEAT_LEN(BEAT_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .play     (play),
        .stop     (stop),
        .loop_en  (loop_en),
`ifdef BEAT_SEQUENCER_FAST_EN
        .fast     (fast),
`endif
        .ibeatNum (ibeatNum),
        .beat_tick(beat_tick),
        .playing  (playing),
        .song_done(song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0;
        m_e    = 0;
        m_tick = 1'b0;
        m_done = 1'b0;
        m_idx  = 12'd0;
        m_play = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic s);
        bit running;
        m_tick = 1'b0;
        m_done = 1'b0;
        if (s) begin
            m_mode = 0;
            m_e    = 0;
        end else begin
            running = (m_mode == 1 && !p) || (m_mode == 2 && p);
            if (p) m_mode = (m_mode == 1) ? 2 : 1;
            if (running) begin
                m_e = m_e + 1;
                if (m_e == BEAT_LEN * DIV) begin
                    m_e    = 0;
                    m_done = 1'b1;
                    if (loop_en) m_tick = 1'b1;
                    else         m_mode = 0;
                end else if (m_e % DIV == 0) begin
                    m_tick = 1'b1;
                end
            end
        end
        m_idx  = 12'(m_e / DIV);
        m_play = (m_mode == 1);
    endtask

    // One clock: drive pulses, let the edge happen, update the model, sample at +1.
    task automatic cycle(input logic p, input logic s);
        play = p;
        stop = s;
        @(posedge clk);
        model_step(p, s);
        #1;
        play = 1'b0;
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        play    = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
`ifdef BEAT_SEQUENCER_FAST_EN
        fast    = 1'b0;
`endif
        model_reset();
        #16;
        total++;
        if (got !== 15'd0) begin
            bad++;
            $display("FAIL reset got=%h want=%h", got, 15'd0);
        end
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", got, want);
        end
    endtask

    task automatic test_play_basic();
        loop_en = 1'b0;
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        total++;
        if (playing !== 1'b1) begin
            bad++;
            $display("FAIL play_start playing=%b want=1", playing);
        end
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b0, 1'b0);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL play_basic edge=%0d got=%h want=%h", e, got, want);
            end
            if (e % 4 == 0) begin
                total++;
                if (ibeatNum !== 12'(e / 4) || beat_tick !== 1'b1) begin
                    bad++;
                    $display("FAIL play_beat edge=%0d idx=%0d tick=%b want idx=%0d tick=1",
                             e, ibeatNum, beat_tick, e / 4);
                end
            end
        end
    endtask

    task automatic test_song_end(input logic lp);
        loop_en = lp;
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        for (int e = 1; e <= 36; e++) begin
            cycle(1'b0, 1'b0);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL song_end loop=%b edge=%0d got=%h want=%h", lp, e, got, want);
            end
            if (e == 28) begin
                total++;
                if (ibeatNum !== 12'd7) begin
                    bad++;
                    $display("FAIL last_beat idx=%0d want=7", ibeatNum);
                end
            end
            if (e == 32) begin
                total++;
                if (ibeatNum !== 12'd0 || song_done !== 1'b1 || beat_tick !== lp || playing !== lp) begin
                    bad++;
                    $display("FAIL song_done loop=%b idx=%0d done=%b tick=%b playing=%b", lp,
                             ibeatNum, song_done, beat_tick, playing);
                end
            end
            if (e == 36) begin
                total++;
                if (ibeatNum !== (lp ? 12'd1 : 12'd0)) begin
                    bad++;
                    $display("FAIL after_end loop=%b idx=%0d want=%0d", lp, ibeatNum, lp ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_pause();
        int ticks;
        loop_en = 1'b0;
        ticks   = 0;
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        for (int e = 1; e <= 22; e++) begin
            cycle((e == 6 || e == 20) ? 1'b1 : 1'b0, 1'b0);
            if (e >= 6 && e < 20 && beat_tick) ticks++;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL pause edge=%0d got=%h want=%h", e, got, want);
            end
        end
        total++;
        if (ticks != 0) begin
            bad++;
            $display("FAIL pause_ticks got=%0d want=0", ticks);
        end
        total++;
        if (ibeatNum !== 12'd2 || beat_tick !== 1'b1 || playing !== 1'b1) begin
            bad++;
            $display("FAIL resume_beat idx=%0d tick=%b playing=%b want 2,1,1", ibeatNum, beat_tick, playing);
        end
    endtask

    task automatic test_stop_terminal();
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        for (int e = 1; e <= 7; e++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        total++;
        if (got !== 15'd0 || got !== want) begin
            bad++;
            $display("FAIL stop_terminal got=%h want=%h", got, 15'd0);
        end
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        total++;
        if (playing !== 1'b0 || got !== want) begin
            bad++;
            $display("FAIL play_and_stop got=%h want=%h", got, want);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        for (int e = 1; e <= 10; e++) cycle(1'b0, 1'b0);
        rst_n = 1'b0;
        #3;
        total++;
        if (got !== 15'd0) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", got, 15'd0);
        end
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL post_reset got=%h want=%h", got, want);
        end
    endtask

    task automatic test_random();
        logic p;
        logic s;
        int   errs;
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
            p = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 149) == 0);
            cycle(p, s);
            total++;
            if (got !== want) begin
                bad++;
                errs++;
                if (errs <= 10) $display("FAIL random cyc=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_play_basic();
        test_song_end(1'b0);
        test_song_end(1'b1);
        test_pause();
        test_stop_terminal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
